aes_round_engine: RTL



---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_round_engine.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and the linear round-step helpers
// used by aes_round_engine.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NR      = 10;
    localparam int KEYSET_W    = 128 * (AES_NR + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One state column, row 0 in the top byte.
    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = col;
        return {xtime(a) ^ xtime(b) ^ b ^ c ^ d,
                a ^ xtime(b) ^ xtime(c) ^ c ^ d,
                a ^ b ^ xtime(c) ^ xtime(d) ^ d,
                xtime(a) ^ a ^ b ^ c ^ xtime(d)};
    endfunction

    // Row r rotates left by r columns: out(row r, col c) = in(row r, col (c+r) mod 4).
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (FIPS-197 Figure 7), one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);

    // Row-major table: entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = SBOX[val];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: one full round per clock between two valid/ready handshakes.
// Define AES_KEY_LATCH_EN to capture keySet at acceptance instead of using it live.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [128*(NUM_ROUNDS+1)-1:0] keySet,
    input  logic [AES_BLOCK_W-1:0]        plainText,
    input  logic                          inValid,
    output logic                          inReady,
    output logic [AES_BLOCK_W-1:0]        cipherText,
    output logic                          outValid,
    input  logic                          outReady
);

    localparam int         KS_W       = 128 * (NUM_ROUNDS + 1);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_fsm_e     fsm, fsm_next;
    logic [3:0]   round;
    logic [127:0] aes_state;
    logic         load_in, load_round;
    logic [KS_W-1:0] keys;
    logic [127:0] round_key, sub_bytes, shifted, mixed, next_state;

`ifdef AES_KEY_LATCH_EN
    logic [KS_W-1:0] key_hold;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_hold <= '0;
        end else if (load_in) begin
            key_hold <= keySet;
        end
    end

    assign keys = key_hold;
`else
    assign keys = keySet;
`endif

    always_comb begin
        round_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (round == 4'(i)) begin
                round_key = keys[KS_W-1-128*i -: 128];
            end
        end
    end

    // ---- round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .val (aes_state[127-8*i -: 8]),
            .sub (sub_bytes[127-8*i -: 8])
        );
    end

    assign shifted = shiftRows(sub_bytes);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127-32*c -: 32] = mixColumn(shifted[127-32*c -: 32]);
    end

    // The final round skips MixColumns.
    assign next_state = ((round == LAST_ROUND) ? shifted : mixed) ^ round_key;

    // ---- control
    always_comb begin
        fsm_next   = fsm;
        inReady    = 1'b0;
        outValid   = 1'b0;
        load_in    = 1'b0;
        load_round = 1'b0;
        case (fsm)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    load_in  = 1'b1;
                    fsm_next = RUN;
                end
            end
            RUN: begin
                load_round = 1'b1;
                if (round == LAST_ROUND) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fsm       <= IDLE;
            round     <= 4'd0;
            aes_state <= '0;
        end else begin
            fsm <= fsm_next;
            if (load_in) begin
                aes_state <= plainText ^ keySet[KS_W-1 -: 128];
                round     <= 4'd1;
            end else if (load_round) begin
                aes_state <= next_state;
                round     <= round + 4'd1;
            end else if (fsm == DONE && outReady) begin
                round <= 4'd0;
            end
        end
    end

    assign cipherText = aes_state;

endmodule
